encoder_4x2_rr: RTL and testbench

- Reverse-direction companion to the 2-bit-select / four-line one-hot decoder in the video display processor datapath.
- Collects request strobes on four lines (in_0..in_3) from downstream units and returns each as a 2-bit index (sel) to the shared control path.
- Uses a valid/ready handshake.
- Requests are latched until the consumer accepts them. Simultaneous requests are serialised by round-robin (or fixed-priority) arbitration.

---
 rtl/encoder_4x2_rr.sv | 112 +++++++++++
 tb/tb_encoder_4x2_rr.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/encoder_4x2_rr.sv
// Four-line request encoder: latches request strobes and returns them one at a
// time as a 2-bit index over a valid/ready handshake, with round-robin or fixed-priority arbitration.
module encoder_4x2_rr #(
    parameter bit RR_EN = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_0,
    input  logic       in_1,
    input  logic       in_2,
    input  logic       in_3,
    input  logic       sel_ready,
    output logic [1:0] sel,
    output logic       sel_valid,
    output logic       multi_hot,
    output logic [3:0] pending
);

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_t;

    state_t     state, state_next;
    logic [1:0] last_grant, last_grant_next;
    logic [1:0] sel_next;
    logic       sel_valid_next;
    logic       multi_hot_next;
    logic [3:0] req_now;
    logic [3:0] clear_mask;
    logic [3:0] pending_next;
    logic [1:0] winner;
    logic       winner_multi;
    logic       load;

    // Round-robin starts just after the last grant; fixed priority always starts at 0.
    function automatic logic [1:0] pick_winner(input logic [3:0] req, input logic [1:0] last);
        logic [1:0] idx;
        logic       found;
        pick_winner = 2'd0;
        found       = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            idx = RR_EN ? (last + 2'(k)) : 2'(k - 1);
            if (!found && req[idx]) begin
                pick_winner = idx;
                found       = 1'b1;
            end
        end
    endfunction

    function automatic logic more_than_one(input logic [3:0] req);
        more_than_one = (req & (req - 4'd1)) != 4'd0;
    endfunction

    assign req_now      = {in_3, in_2, in_1, in_0};
    assign clear_mask   = (sel_valid && sel_ready) ? (4'b0001 << sel) : 4'b0000;
    // Set wins: a strobe arriving on the acceptance edge re-latches its own bit.
    assign pending_next = (pending & ~clear_mask) | req_now;
    assign winner       = pick_winner(pending_next, last_grant);
    assign winner_multi = more_than_one(pending_next);

    always_comb begin
        state_next      = state;
        sel_next        = sel;
        sel_valid_next  = sel_valid;
        multi_hot_next  = multi_hot;
        last_grant_next = last_grant;
        load            = 1'b0;
        case (state)
            IDLE: begin
                if (pending_next != 4'd0) load = 1'b1;
            end
            PRESENT: begin
                if (sel_ready) begin
                    if (pending_next != 4'd0) begin
                        load = 1'b1;
                    end else begin
                        sel_valid_next = 1'b0;
                        state_next     = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
        if (load) begin
            sel_next        = winner;
            sel_valid_next  = 1'b1;
            last_grant_next = winner;
            multi_hot_next  = winner_multi;
            state_next      = PRESENT;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            sel        <= 2'b00;
            sel_valid  <= 1'b0;
            multi_hot  <= 1'b0;
            pending    <= 4'b0000;
            last_grant <= 2'd3;
        end else begin
            state      <= state_next;
            sel        <= sel_next;
            sel_valid  <= sel_valid_next;
            multi_hot  <= multi_hot_next;
            pending    <= pending_next;
            last_grant <= last_grant_next;
        end
    end

endmodule

// File: tb/tb_encoder_4x2_rr.sv
// Directed bench for encoder_4x2_rr: a round-robin and a fixed-priority instance
// driven from shared inputs, checked against hand-computed values.
module tb_encoder_4x2_rr;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_0, in_1, in_2, in_3;
    logic       sel_ready;
    logic [1:0] sel_rr, sel_fp;
    logic       sel_valid_rr, sel_valid_fp;
    logic       multi_hot_rr, multi_hot_fp;
    logic [3:0] pending_rr, pending_fp;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    encoder_4x2_rr #(.RR_EN(1'b1)) dut_rr (
        .clk(clk), .rst_n(rst_n),
        .in_0(in_0), .in_1(in_1), .in_2(in_2), .in_3(in_3),
        .sel_ready(sel_ready),
        .sel(sel_rr), .sel_valid(sel_valid_rr),
        .multi_hot(multi_hot_rr), .pending(pending_rr)
    );

    encoder_4x2_rr #(.RR_EN(1'b0)) dut_fp (
        .clk(clk), .rst_n(rst_n),
        .in_0(in_0), .in_1(in_1), .in_2(in_2), .in_3(in_3),
        .sel_ready(sel_ready),
        .sel(sel_fp), .sel_valid(sel_valid_fp),
        .multi_hot(multi_hot_fp), .pending(pending_fp)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        tests_run++;
        assert (obs === exp)
        else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input logic [3:0] r);
        {in_3, in_2, in_1, in_0} = r;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n     = 1'b0;
        sel_ready = 1'b0;
        set_req(4'b0000);

        // reset, with a request strobe that must be discarded
        tick();
        set_req(4'b0001);
        tick();
        chk("rst_sel", sel_rr, 2'd0);
        chk("rst_valid", sel_valid_rr, 1'b0);
        chk("rst_mh", multi_hot_rr, 1'b0);
        chk("rst_pending", pending_rr, 4'b0000);
        set_req(4'b0000);
        rst_n = 1'b1;
        tick();
        chk("rst_discard_valid", sel_valid_rr, 1'b0);
        chk("rst_discard_pending", pending_rr, 4'b0000);

        // single requests, one-cycle pulses with sel_ready high
        sel_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_req(4'b0001 << i);
            tick();
            chk("single_sel", {2'b00, sel_rr}, 4'(i));
            chk("single_valid", sel_valid_rr, 1'b1);
            chk("single_mh", multi_hot_rr, 1'b0);
            chk("single_pending", pending_rr, 4'b0001 << i);
            set_req(4'b0000);
            tick();
            chk("single_drop_valid", sel_valid_rr, 1'b0);
            chk("single_drop_pending", pending_rr, 4'b0000);
        end

        // simultaneous requests after reset: 0,1,2,3 back to back
        do_reset();
        set_req(4'b1111);
        tick();
        set_req(4'b0000);
        chk("all_sel0", sel_rr, 2'd0);
        chk("all_mh0", multi_hot_rr, 1'b1);
        chk("all_pend0", pending_rr, 4'b1111);
        tick();
        chk("all_sel1", sel_rr, 2'd1);
        chk("all_mh1", multi_hot_rr, 1'b1);
        tick();
        chk("all_sel2", sel_rr, 2'd2);
        chk("all_mh2", multi_hot_rr, 1'b1);
        tick();
        chk("all_sel3", sel_rr, 2'd3);
        chk("all_mh3", multi_hot_rr, 1'b0);
        chk("all_valid3", sel_valid_rr, 1'b1);
        tick();
        chk("all_done_valid", sel_valid_rr, 1'b0);
        chk("all_done_pending", pending_rr, 4'b0000);

        // backpressure: sel=2 held for five cycles while in_1 accumulates
        sel_ready = 1'b0;
        set_req(4'b0100);
        tick();
        set_req(4'b0000);
        chk("bp_sel", sel_rr, 2'd2);
        chk("bp_valid", sel_valid_rr, 1'b1);
        for (int c = 0; c < 4; c++) begin
            set_req(c == 0 ? 4'b0010 : 4'b0000);
            tick();
            chk("bp_hold_sel", sel_rr, 2'd2);
            chk("bp_hold_valid", sel_valid_rr, 1'b1);
            chk("bp_hold_mh", multi_hot_rr, 1'b0);
        end
        set_req(4'b0000);
        chk("bp_pending", pending_rr, 4'b0110);
        sel_ready = 1'b1;
        tick();
        chk("bp_next_sel", sel_rr, 2'd1);
        chk("bp_next_valid", sel_valid_rr, 1'b1);
        chk("bp_next_pending", pending_rr, 4'b0010);
        tick();
        chk("bp_end_valid", sel_valid_rr, 1'b0);

        // set wins: in_3 held across its own acceptance
        set_req(4'b1000);
        tick();
        chk("sw_sel", sel_rr, 2'd3);
        tick();
        chk("sw_again_sel", sel_rr, 2'd3);
        chk("sw_again_valid", sel_valid_rr, 1'b1);
        chk("sw_pending", pending_rr, 4'b1000);
        set_req(4'b0000);
        tick();
        chk("sw_end_valid", sel_valid_rr, 1'b0);
        chk("sw_end_pending", pending_rr, 4'b0000);

        // reset mid-operation with pending=1011 and a grant in flight
        sel_ready = 1'b0;
        set_req(4'b0010);
        tick();
        set_req(4'b1001);
        tick();
        set_req(4'b0000);
        chk("mid_pending", pending_rr, 4'b1011);
        chk("mid_sel", sel_rr, 2'd1);
        chk("mid_valid", sel_valid_rr, 1'b1);
        do_reset();
        chk("mid_rst_valid", sel_valid_rr, 1'b0);
        chk("mid_rst_pending", pending_rr, 4'b0000);
        chk("mid_rst_sel", sel_rr, 2'd0);
        chk("mid_rst_mh", multi_hot_rr, 1'b0);
        sel_ready = 1'b1;
        set_req(4'b1001);
        tick();
        set_req(4'b0000);
        chk("post_rst_sel", sel_rr, 2'd0);
        chk("post_rst_mh", multi_hot_rr, 1'b1);
        tick();
        chk("post_rst_sel2", sel_rr, 2'd3);
        chk("post_rst_mh2", multi_hot_rr, 1'b0);
        tick();
        chk("post_rst_end", sel_valid_rr, 1'b0);

        // fixed priority vs round-robin with in_0 and in_3 held high
        do_reset();
        set_req(4'b1001);
        for (int c = 0; c < 4; c++) begin
            tick();
            chk("fp_sel", sel_fp, 2'd0);
            chk("fp_valid", sel_valid_fp, 1'b1);
            chk("fp_pending", pending_fp, 4'b1001);
            chk("rr_alt_sel", sel_rr, (c % 2 == 0) ? 2'd0 : 2'd3);
        end
        set_req(4'b1000);
        tick();
        chk("fp_drop0_sel", sel_fp, 2'd3);
        chk("fp_drop0_valid", sel_valid_fp, 1'b1);
        set_req(4'b0000);
        tick();
        chk("fp_end_valid", sel_valid_fp, 1'b0);
        chk("fp_end_pending", pending_fp, 4'b0000);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
